hx8357_fill_sched: RTL

- Sequences a rectangular solid-colour fill on the HX8357 by driving the existing display bus controller's word interface (cmd/data strobes, data_lines, transmission_cmpl).
- Issues CASET and PASET, each with 4 parameter bytes, then RAMWR, then streams N identical pixel words.
- Sits between the application FSM and the bus controller, replacing hand-coded fill sequences.

---
 rtl/hx8357_fill_sched.sv | 286 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/hx8357_fill_sched.sv
// hx8357_fill_sched: sequences a rectangular solid-colour fill on the HX8357
// panel through the display bus controller's word interface. For each fill it
// issues CASET and PASET, each with four parameter bytes, then RAMWR, and then
// streams NPIX identical pixel words, one word per transmission_cmpl handshake.
//
// Optional feature: define HX8357_FILL_TIMEOUT_EN to enable a WAIT watchdog.
// When no transmission_cmpl arrives for TIMEOUT cycles, the fill aborts with
// done and err. Without the macro, WAIT lasts until the controller answers.
module hx8357_fill_sched #(
    parameter int unsigned WIDTH     = 320,
    parameter int unsigned HEIGHT    = 480,
    parameter logic [7:0]  CMD_CASET = 8'h2A,
    parameter logic [7:0]  CMD_PASET = 8'h2B,
    parameter logic [7:0]  CMD_RAMWR = 8'h2C,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic        clk,
    input  logic        res,
    input  logic        start,
    input  logic [8:0]  x0,
    input  logic [8:0]  x1,
    input  logic [8:0]  y0,
    input  logic [8:0]  y1,
    input  logic [15:0] color,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        cmd,
    output logic        data,
    output logic [15:0] data_lines,
    input  logic        transmission_cmpl
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_ISSUE = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    // Index 0..10 walks the 11-word header; IDX_PIX marks the pixel phase.
    localparam logic [3:0] HDR_LAST = 4'd10;
    localparam logic [3:0] IDX_PIX  = 4'd11;
    localparam logic [8:0] X_MAX    = 9'(WIDTH - 1);
    localparam logic [8:0] Y_MAX    = 9'(HEIGHT - 1);

    // Header word at position idx as {is_cmd, word}.
    // Coordinates are zero-extended to 16 bits and sent high byte first.
    function automatic logic [16:0] header_word(
        input logic [3:0] idx,
        input logic [8:0] xa,
        input logic [8:0] xb,
        input logic [8:0] ya,
        input logic [8:0] yb
    );
        logic [15:0] xa_w;
        logic [15:0] xb_w;
        logic [15:0] ya_w;
        logic [15:0] yb_w;
        xa_w = {7'd0, xa};
        xb_w = {7'd0, xb};
        ya_w = {7'd0, ya};
        yb_w = {7'd0, yb};
        case (idx)
            4'd0:    header_word = {1'b1, 8'h00, CMD_CASET};
            4'd1:    header_word = {1'b0, 8'h00, xa_w[15:8]};
            4'd2:    header_word = {1'b0, 8'h00, xa_w[7:0]};
            4'd3:    header_word = {1'b0, 8'h00, xb_w[15:8]};
            4'd4:    header_word = {1'b0, 8'h00, xb_w[7:0]};
            4'd5:    header_word = {1'b1, 8'h00, CMD_PASET};
            4'd6:    header_word = {1'b0, 8'h00, ya_w[15:8]};
            4'd7:    header_word = {1'b0, 8'h00, ya_w[7:0]};
            4'd8:    header_word = {1'b0, 8'h00, yb_w[15:8]};
            4'd9:    header_word = {1'b0, 8'h00, yb_w[7:0]};
            4'd10:   header_word = {1'b1, 8'h00, CMD_RAMWR};
            default: header_word = {1'b0, 16'h0000};
        endcase
    endfunction

    state_t      state_q, state_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        cmd_q, cmd_d;
    logic        data_q, data_d;
    logic [15:0] lines_q, lines_d;
    logic [8:0]  x0_q, x0_d;
    logic [8:0]  x1_q, x1_d;
    logic [8:0]  y0_q, y0_d;
    logic [8:0]  y1_q, y1_d;
    logic [15:0] color_q, color_d;
    logic [3:0]  idx_q, idx_d;
    logic [17:0] npix_q, npix_d;
    logic [17:0] pix_q, pix_d;
`ifdef HX8357_FILL_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
    logic [15:0] tmo_q, tmo_d;
`else
    // Without the watchdog TIMEOUT has no effect; any value is accepted.
    if (TIMEOUT == 32'd0) begin : g_timeout_unused
    end
`endif

    logic        bad_rect_s;
    logic [8:0]  width_s;
    logic [8:0]  height_s;
    logic [17:0] npix_s;
    logic [16:0] hdr_next_s;

    // Rectangle validation, pixel count and the next header word.
    always_comb begin
        bad_rect_s = (x0_q > x1_q) || (y0_q > y1_q) || (x1_q > X_MAX) || (y1_q > Y_MAX);
        width_s    = x1_q - x0_q + 9'd1;
        height_s   = y1_q - y0_q + 9'd1;
        npix_s     = {9'd0, width_s} * {9'd0, height_s};
        hdr_next_s = header_word(idx_q + 4'd1, x0_q, x1_q, y0_q, y1_q);
    end

    // Next-state and next-output logic for the fill sequencer.
    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        cmd_d   = 1'b0;
        data_d  = 1'b0;
        lines_d = lines_q;
        x0_d    = x0_q;
        x1_d    = x1_q;
        y0_d    = y0_q;
        y1_d    = y1_q;
        color_d = color_q;
        idx_d   = idx_q;
        npix_d  = npix_q;
        pix_d   = pix_q;
`ifdef HX8357_FILL_TIMEOUT_EN
        tmo_d   = tmo_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    x0_d    = x0;
                    x1_d    = x1;
                    y0_d    = y0;
                    y1_d    = y1;
                    color_d = color;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = ST_CHECK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (bad_rect_s) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    npix_d  = npix_s;
                    idx_d   = 4'd0;
                    cmd_d   = 1'b1;
                    lines_d = {8'h00, CMD_CASET};
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // The strobe was registered on entry; drop it and wait for the ack.
                state_d = ST_WAIT;
`ifdef HX8357_FILL_TIMEOUT_EN
                tmo_d   = 16'd0;
`endif
            end
            ST_WAIT: begin
                if (transmission_cmpl) begin
`ifdef HX8357_FILL_TIMEOUT_EN
                    tmo_d = 16'd0;
`endif
                    if (idx_q < HDR_LAST) begin
                        idx_d   = idx_q + 4'd1;
                        cmd_d   = hdr_next_s[16];
                        data_d  = ~hdr_next_s[16];
                        lines_d = hdr_next_s[15:0];
                        state_d = ST_ISSUE;
                    end else if (idx_q == HDR_LAST) begin
                        // RAMWR accepted: load the pixel counter and send the first pixel.
                        idx_d   = IDX_PIX;
                        pix_d   = npix_q;
                        data_d  = 1'b1;
                        lines_d = color_q;
                        state_d = ST_ISSUE;
                    end else if (pix_q <= 18'd1) begin
                        // Last pixel accepted; saturate at zero rather than wrap.
                        pix_d   = 18'd0;
                        idx_d   = 4'd0;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        lines_d = 16'h0000;
                        state_d = ST_IDLE;
                    end else begin
                        pix_d   = pix_q - 18'd1;
                        data_d  = 1'b1;
                        lines_d = color_q;
                        state_d = ST_ISSUE;
                    end
                end
`ifdef HX8357_FILL_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    // Controller stopped answering: abandon the remaining words.
                    tmo_d   = 16'd0;
                    pix_d   = 18'd0;
                    idx_d   = 4'd0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    lines_d = 16'h0000;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
`else
                else begin
                    state_d = ST_WAIT;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                lines_d = 16'h0000;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (res) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cmd_q   <= 1'b0;
            data_q  <= 1'b0;
            lines_q <= 16'h0000;
            x0_q    <= 9'd0;
            x1_q    <= 9'd0;
            y0_q    <= 9'd0;
            y1_q    <= 9'd0;
            color_q <= 16'h0000;
            idx_q   <= 4'd0;
            npix_q  <= 18'd0;
            pix_q   <= 18'd0;
`ifdef HX8357_FILL_TIMEOUT_EN
            tmo_q   <= 16'd0;
`endif
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cmd_q   <= cmd_d;
            data_q  <= data_d;
            lines_q <= lines_d;
            x0_q    <= x0_d;
            x1_q    <= x1_d;
            y0_q    <= y0_d;
            y1_q    <= y1_d;
            color_q <= color_d;
            idx_q   <= idx_d;
            npix_q  <= npix_d;
            pix_q   <= pix_d;
`ifdef HX8357_FILL_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign cmd        = cmd_q;
    assign data       = data_q;
    assign data_lines = lines_q;

endmodule
